adder_result_sink: RTL and testbench

//  Receiving end of the adder output stream (valid_out/o). Buffers each result in a FIFO and serves it

---
 rtl/adder_pkg.sv | 35 +++
 rtl/adder_result_sink_fifo.sv | 76 +++++++
 rtl/adder_result_sink.sv | 122 ++++++++++++
 tb/tb_adder_result_sink.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: IEEE half-precision field layout
// and a classifier used to flag special values on the result stream.
package adder_pkg;

    localparam int         F16_EXP_MSB  = 14;
    localparam int         F16_EXP_LSB  = 10;
    localparam int         F16_MANT_W   = 10;
    localparam logic [4:0] F16_EXP_ALL1 = 5'h1f;

    typedef enum logic [1:0] {
        F16_NORMAL,
        F16_ZERO,
        F16_INF,
        F16_NAN
    } f16_class_t;

    // Subnormals are reported as F16_NORMAL; only zero and the all-ones exponent are special.
    function automatic f16_class_t f16_classify(input logic [15:0] x);
        logic [4:0]            exp_f;
        logic [F16_MANT_W-1:0] mant_f;
        f16_class_t            cls;
        exp_f  = x[F16_EXP_MSB:F16_EXP_LSB];
        mant_f = x[F16_MANT_W-1:0];
        if (exp_f == F16_EXP_ALL1) begin
            if (mant_f != '0) cls = F16_NAN;
            else              cls = F16_INF;
        end else if (exp_f == 5'h00 && mant_f == '0) begin
            cls = F16_ZERO;
        end else begin
            cls = F16_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/adder_result_sink_fifo.sv
// First-word fall-through FIFO with a registered head: rd_data/rd_valid come
// straight from flops, and the head is refilled from memory or the incoming word.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             push, pop;

    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign rd_valid = valid_q;
    assign rd_data  = head_q;

    always_comb begin
        pop      = valid_q && rd_ready;
        push     = wr_valid && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // The next head is the word being written when it lands on the new read slot
        // (empty FIFO, or count==1 with push+pop); otherwise it is already in memory.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
            else                                head_d = mem_q[rd_ptr_d];
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/adder_result_sink.sv
// Receiving end of the adder result stream: buffers results, counts beats lost
// to a full buffer, and keeps sticky NaN/Inf flags for half-precision data.
module adder_result_sink
    import adder_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int DEPTH   = 4,
    parameter int FLOAT16 = 1,
    parameter int DROP_W  = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       valid_in,
    input  logic [BITS-1:0]            data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BITS-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       nan_seen,
    output logic                       inf_seen,
    input  logic                       clr_flags
);

    localparam int               CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic              pop, drop;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    sync_fifo_fwft #(
        .WIDTH (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (valid_in),
        .wr_data  (data_in),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .count    (count),
        .full     (full)
    );

    assign drop_cnt = drop_cnt_q;

    // A drop in the same cycle as a clear restarts the count at 1 rather than 0.
    always_comb begin
        pop        = out_valid && out_ready;
        drop       = valid_in && full && !pop;
        drop_cnt_d = clr_flags ? '0 : drop_cnt_q;
        if (drop && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    if (FLOAT16 != 0) begin : g_f16
        f16_class_t cls;
        logic       nan_seen_q, nan_seen_d;
        logic       inf_seen_q, inf_seen_d;

        // Dropped beats are still classified; a set in the clear cycle wins.
        always_comb begin
            cls        = f16_classify(data_in[15:0]);
            nan_seen_d = (nan_seen_q && !clr_flags) || (valid_in && (cls == F16_NAN));
            inf_seen_d = (inf_seen_q && !clr_flags) || (valid_in && (cls == F16_INF));
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                nan_seen_q <= 1'b0;
                inf_seen_q <= 1'b0;
            end else begin
                nan_seen_q <= nan_seen_d;
                inf_seen_q <= inf_seen_d;
            end
        end

        assign nan_seen = nan_seen_q;
        assign inf_seen = inf_seen_q;
    end else begin : g_no_f16
        assign nan_seen = 1'b0;
        assign inf_seen = 1'b0;
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (!resetn) count <= DEPTH_C)
        else $error("count exceeds DEPTH");
    a_valid_cnt: assert property (@(posedge clk) disable iff (!resetn) out_valid == (count != '0))
        else $error("out_valid disagrees with count");
    a_hold_data: assert property (@(posedge clk) disable iff (!resetn)
                                  (out_valid && !out_ready) |=> $stable(out_data))
        else $error("out_data changed while stalled");

    logic            hold_q;
    logic [BITS-1:0] prev_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_q      <= 1'b0;
            prev_data_q <= '0;
        end else begin
            hold_q      <= out_valid && !out_ready;
            prev_data_q <= out_data;
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (count > DEPTH_C)                  $fatal(1, "count exceeds DEPTH");
            if (out_valid != (count != '0))       $fatal(1, "out_valid disagrees with count");
            if (hold_q && out_data != prev_data_q) $fatal(1, "out_data changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_sink.sv
// Directed bench for adder_result_sink: stimulus queues expected head words,
// a negedge monitor pops and compares them on every accepted output.
module tb_adder_result_sink;

    localparam int BITS   = 16;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              valid_in = 1'b0;
    logic [BITS-1:0]   data_in = '0;
    logic              out_ready = 1'b0;
    logic              clr_flags = 1'b0;
    logic              out_valid;
    logic [BITS-1:0]   out_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic [DROP_W-1:0] drop_cnt;
    logic              nan_seen;
    logic              inf_seen;

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] exp_q[$];

    adder_result_sink #(
        .BITS    (BITS),
        .DEPTH   (DEPTH),
        .FLOAT16 (1),
        .DROP_W  (DROP_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .drop_cnt  (drop_cnt),
        .nan_seen  (nan_seen),
        .inf_seen  (inf_seen),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BITS-1:0] d, input bit expect_accept);
        valid_in = 1'b1;
        data_in  = d;
        if (expect_accept) exp_q.push_back(d);
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                chk("head_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset then idle
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_data", {16'h0, out_data}, 0);
        chk("rst_count", {29'h0, count}, 0);
        chk("rst_full", {31'h0, full}, 0);
        chk("rst_drop_cnt", {24'h0, drop_cnt}, 0);
        chk("rst_nan", {31'h0, nan_seen}, 0);
        chk("rst_inf", {31'h0, inf_seen}, 0);
        #21 resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out_valid", {31'h0, out_valid}, 0);
        end

        // Single beat, consumer ready
        out_ready = 1'b1;
        push(16'h3C00, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("single_valid", {31'h0, out_valid}, 1);
        chk("single_data", {16'h0, out_data}, 32'h3C00);
        chk("single_count1", {29'h0, count}, 1);
        tick();
        chk("single_count0", {29'h0, count}, 0);

        // Overflow with consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            push(BITS'(i), i <= DEPTH);
            tick();
        end
        valid_in = 1'b0;
        chk("ovf_full", {31'h0, full}, 1);
        chk("ovf_count", {29'h0, count}, 4);
        chk("ovf_drop", {24'h0, drop_cnt}, 2);
        chk("ovf_head", {16'h0, out_data}, 32'h0001);

        // Push into full FIFO while popping
        out_ready = 1'b1;
        push(16'hAAAA, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("fullpp_count", {29'h0, count}, 4);
        chk("fullpp_drop", {24'h0, drop_cnt}, 2);
        repeat (6) tick();
        chk("drain_count", {29'h0, count}, 0);
        chk("drain_valid", {31'h0, out_valid}, 0);

        // Special-value flags
        push(16'h7C00, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("inf_set", {31'h0, inf_seen}, 1);
        chk("inf_nan_clear", {31'h0, nan_seen}, 0);
        push(16'h7E01, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("nan_set", {31'h0, nan_seen}, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_nan", {31'h0, nan_seen}, 0);
        chk("clr_inf", {31'h0, inf_seen}, 0);
        chk("clr_drop", {24'h0, drop_cnt}, 0);
        clr_flags = 1'b1;
        push(16'hFC00, 1'b1);
        tick();
        clr_flags = 1'b0;
        valid_in = 1'b0;
        chk("setwin_inf", {31'h0, inf_seen}, 1);
        chk("setwin_nan", {31'h0, nan_seen}, 0);
        repeat (2) tick();

        // Drop in the clear cycle, classification of a dropped beat
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'h0011 + BITS'(i), 1'b1);
            tick();
        end
        push(16'h0005, 1'b0);
        tick();
        chk("drop_one", {24'h0, drop_cnt}, 1);
        clr_flags = 1'b1;
        push(16'h7C00, 1'b0);
        tick();
        clr_flags = 1'b0;
        valid_in = 1'b0;
        chk("dropwin_cnt", {24'h0, drop_cnt}, 1);
        chk("dropwin_inf", {31'h0, inf_seen}, 1);
        chk("dropwin_count", {29'h0, count}, 4);

        // Asynchronous reset mid-drain
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("middrain_count", {29'h0, count}, 3);
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", {31'h0, out_valid}, 0);
        chk("arst_data", {16'h0, out_data}, 0);
        chk("arst_count", {29'h0, count}, 0);
        chk("arst_full", {31'h0, full}, 0);
        chk("arst_drop", {24'h0, drop_cnt}, 0);
        chk("arst_inf", {31'h0, inf_seen}, 0);
        repeat (2) tick();
        #2 resetn = 1'b1;
        tick();
        chk("post_rst_count", {29'h0, count}, 0);
        chk("post_rst_valid", {31'h0, out_valid}, 0);
        push(16'h1234, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("post_rst_head_v", {31'h0, out_valid}, 1);
        chk("post_rst_head_d", {16'h0, out_data}, 32'h1234);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("final_count", {29'h0, count}, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
